// File: rtl/exc_intr_ctrl.sv
// Exception / interrupt controller for the static pipeline CPU.
// Prioritises synchronous exceptions over edge-triggered external interrupts
// and presents a single registered cause to the pipeline.
//
// Handshake: exc_req rises with cause/irq_id already valid and all three
// hold steady until the pipeline answers with exc_ack. The ack cycle is the
// one transfer point. exc_req drops on the following edge and the handler
// phase begins. exc_ack seen while no request is outstanding has no effect.
module exc_intr_ctrl #(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_ID_W = 2,
    parameter int CAUSE_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                syscall,
    input  logic                brk,
    input  logic                teq,
    input  logic                zero,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    input  logic                exc_ack,
    input  logic                eret,
    output logic                exc_req,
    output logic [CAUSE_W-1:0]  cause,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [NUM_IRQ-1:0]  pending,
    output logic [NUM_IRQ-1:0]  mask,
    output logic                ie,
    output logic                in_handler,
    output logic                double_fault,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    localparam logic [CAUSE_W-1:0] CAUSE_IRQ     = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] CAUSE_SYSCALL = CAUSE_W'(8);
    localparam logic [CAUSE_W-1:0] CAUSE_BRK     = CAUSE_W'(9);
    localparam logic [CAUSE_W-1:0] CAUSE_TEQ     = CAUSE_W'(13);

    state_t                state_q;
    state_t                state_d;
    logic                  exc_req_d;
    logic [CAUSE_W-1:0]    cause_d;
    logic [IRQ_ID_W-1:0]   irq_id_d;
    logic                  ie_d;
    logic                  in_handler_d;
    logic                  ack_take;

    logic [NUM_IRQ-1:0]    irq_q;
    logic [NUM_IRQ-1:0]    irq_rise;
    logic [NUM_IRQ-1:0]    irq_clr;
    logic [NUM_IRQ-1:0]    pending_d;
    logic [NUM_IRQ-1:0]    eligible;
    logic                  irq_any;
    logic [IRQ_ID_W-1:0]   irq_sel;
    logic                  sync_exc;

    assign dbg_state = state_q;

    // Decode synchronous exceptions and the set of interrupts allowed to win.
    always_comb begin
        sync_exc = syscall | brk | (teq & zero);
        eligible = ie ? (pending & mask) : '0;
        irq_any  = |eligible;
    end

    // Lowest-index eligible interrupt wins; scanning downward leaves it last.
    always_comb begin
        irq_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                irq_sel = IRQ_ID_W'(i);
            end
        end
    end

    // Next-state and registered-output logic for IDLE -> REQ -> HANDLER.
    always_comb begin
        state_d      = state_q;
        exc_req_d    = exc_req;
        cause_d      = cause;
        irq_id_d     = irq_id;
        ie_d         = ie;
        in_handler_d = in_handler;
        ack_take     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_exc) begin
                    state_d   = ST_REQ;
                    exc_req_d = 1'b1;
                    irq_id_d  = '0;
                    if (syscall) begin
                        cause_d = CAUSE_SYSCALL;
                    end else if (brk) begin
                        cause_d = CAUSE_BRK;
                    end else begin
                        cause_d = CAUSE_TEQ;
                    end
                end else if (irq_any) begin
                    state_d   = ST_REQ;
                    exc_req_d = 1'b1;
                    cause_d   = CAUSE_IRQ;
                    irq_id_d  = irq_sel;
                end
            end
            ST_REQ: begin
                if (exc_ack) begin
                    state_d      = ST_HANDLER;
                    exc_req_d    = 1'b0;
                    cause_d      = '0;
                    irq_id_d     = '0;
                    ie_d         = 1'b0;
                    in_handler_d = 1'b1;
                    ack_take     = 1'b1;
                end
            end
            ST_HANDLER: begin
                if (eret) begin
                    state_d      = ST_IDLE;
                    ie_d         = 1'b1;
                    in_handler_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending bits: new rising edges set, the acked interrupt clears, set wins.
    always_comb begin
        irq_rise  = irq & ~irq_q;
        irq_clr   = (ack_take && (cause == CAUSE_IRQ)) ? (NUM_IRQ'(1) << irq_id) : '0;
        pending_d = (pending & ~irq_clr) | irq_rise;
    end

    // FSM state and the handshake-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            exc_req    <= 1'b0;
            cause      <= '0;
            irq_id     <= '0;
            ie         <= 1'b1;
            in_handler <= 1'b0;
        end else begin
            state_q    <= state_d;
            exc_req    <= exc_req_d;
            cause      <= cause_d;
            irq_id     <= irq_id_d;
            ie         <= ie_d;
            in_handler <= in_handler_d;
        end
    end

    // Interrupt history, pending, mask and the sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q        <= '0;
            pending      <= '0;
            mask         <= '0;
            double_fault <= 1'b0;
        end else begin
            irq_q   <= irq;
            pending <= pending_d;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            if (sync_exc && (state_q != ST_IDLE)) begin
                double_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exc_intr_ctrl.sv
// Self-checking bench for exc_intr_ctrl: directed scenarios plus a
// randomized run compared against a behavioural model.
module tb_exc_intr_ctrl;

    localparam int NUM_IRQ  = 4;
    localparam int IRQ_ID_W = 2;
    localparam int CAUSE_W  = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                syscall;
    logic                brk;
    logic                teq;
    logic                zero;
    logic [NUM_IRQ-1:0]  irq;
    logic                mask_we;
    logic [NUM_IRQ-1:0]  mask_wdata;
    logic                exc_ack;
    logic                eret;
    logic                exc_req;
    logic [CAUSE_W-1:0]  cause;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [NUM_IRQ-1:0]  pending;
    logic [NUM_IRQ-1:0]  mask;
    logic                ie;
    logic                in_handler;
    logic                double_fault;
    logic [1:0]          dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: request flag, handler flag and architectural registers.
    logic               m_req;
    logic               m_hand;
    logic               m_ie;
    logic               m_df;
    logic [4:0]         m_cause;
    logic [1:0]         m_id;
    logic [3:0]         m_pend;
    logic [3:0]         m_mask;
    logic [3:0]         m_prev;

    exc_intr_ctrl #(
        .NUM_IRQ (NUM_IRQ),
        .IRQ_ID_W(IRQ_ID_W),
        .CAUSE_W (CAUSE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .syscall     (syscall),
        .brk         (brk),
        .teq         (teq),
        .zero        (zero),
        .irq         (irq),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .exc_ack     (exc_ack),
        .eret        (eret),
        .exc_req     (exc_req),
        .cause       (cause),
        .irq_id      (irq_id),
        .pending     (pending),
        .mask        (mask),
        .ie          (ie),
        .in_handler  (in_handler),
        .double_fault(double_fault),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Model update for one rising edge, computed from the controller's rules.
    task automatic model_edge();
        logic       sync_exc;
        logic [3:0] elig;
        logic [3:0] newp;
        if (rst) begin
            m_req = 0; m_hand = 0; m_ie = 1; m_df = 0;
            m_cause = 0; m_id = 0; m_pend = 0; m_mask = 0; m_prev = 0;
            return;
        end
        sync_exc = syscall | brk | (teq & zero);
        elig     = m_ie ? (m_pend & m_mask) : 4'b0000;
        newp     = m_pend;
        if (!m_req && !m_hand) begin
            if (sync_exc) begin
                m_req   = 1;
                m_id    = 0;
                m_cause = syscall ? 5'd8 : (brk ? 5'd9 : 5'd13);
            end else if (elig != 0) begin
                m_req   = 1;
                m_cause = 0;
                for (int i = 3; i >= 0; i--) if (elig[i]) m_id = 2'(i);
            end
        end else begin
            if (sync_exc) m_df = 1;
            if (m_req && exc_ack) begin
                if (m_cause == 0) newp[m_id] = 1'b0;
                m_req = 0; m_hand = 1; m_ie = 0;
            end else if (m_hand && eret) begin
                m_hand = 0; m_ie = 1;
            end
        end
        m_pend = newp | (irq & ~m_prev);
        m_prev = irq;
        if (mask_we) m_mask = mask_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; syscall = 0; brk = 0; teq = 0; zero = 0; irq = '0;
        mask_we = 0; mask_wdata = '0; exc_ack = 0; eret = 0;
    endtask

    task automatic do_ack();
        exc_ack = 1; tick(); exc_ack = 0;
    endtask

    task automatic do_eret();
        eret = 1; tick(); eret = 0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1; mask_wdata = m; tick(); mask_we = 0; mask_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; syscall = 1; irq = 4'hf; mask_we = 1; mask_wdata = 4'hf;
        tick(); tick();
        n_tests++; if (exc_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", exc_req); end
        n_tests++; if (cause !== 5'd0 || irq_id !== 2'd0) begin n_fail++; $display("FAIL reset_cause: got %b/%0d want 0/0", cause, irq_id); end
        n_tests++; if (pending !== 4'h0 || mask !== 4'h0) begin n_fail++; $display("FAIL reset_regs: pend %b mask %b want 0000 0000", pending, mask); end
        n_tests++; if (ie !== 1'b1 || in_handler !== 1'b0 || double_fault !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: ie %b inh %b df %b want 1 0 0", ie, in_handler, double_fault); end
        // A level held high across reset release shows up as an edge.
        idle_inputs(); irq = 4'b0001; rst = 1; tick();
        rst = 0; tick();
        n_tests++; if (pending !== 4'b0001 || exc_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_level_edge: pend %b req %b want 0001 0", pending, exc_req); end
        irq = 0; rst = 1; tick(); rst = 0; tick();
    endtask

    task automatic test_syscall();
        idle_inputs();
        exc_ack = 1; tick(); exc_ack = 0;
        n_tests++; if (in_handler !== 1'b0 || exc_req !== 1'b0) begin n_fail++; $display("FAIL ack_in_idle: inh %b req %b want 0 0", in_handler, exc_req); end
        syscall = 1; tick(); syscall = 0;
        n_tests++; if (exc_req !== 1'b1 || cause !== 5'b01000) begin n_fail++; $display("FAIL sys_req: req %b cause %b want 1 01000", exc_req, cause); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (exc_req !== 1'b1 || cause !== 5'b01000) begin n_fail++; $display("FAIL sys_hold%0d: req %b cause %b want 1 01000", k, exc_req, cause); end
        end
        do_ack();
        n_tests++; if (exc_req !== 1'b0 || ie !== 1'b0 || in_handler !== 1'b1) begin
            n_fail++; $display("FAIL sys_ack: req %b ie %b inh %b want 0 0 1", exc_req, ie, in_handler); end
        do_eret();
        n_tests++; if (in_handler !== 1'b0 || ie !== 1'b1 || exc_req !== 1'b0) begin
            n_fail++; $display("FAIL sys_eret: inh %b ie %b req %b want 0 1 0", in_handler, ie, exc_req); end
    endtask

    task automatic test_priority();
        idle_inputs();
        syscall = 1; brk = 1; teq = 1; zero = 1; tick(); idle_inputs();
        n_tests++; if (exc_req !== 1'b1 || cause !== 5'b01000) begin n_fail++; $display("FAIL prio_all: req %b cause %b want 1 01000", exc_req, cause); end
        do_ack(); do_eret();
        brk = 1; teq = 1; zero = 1; tick(); idle_inputs();
        n_tests++; if (exc_req !== 1'b1 || cause !== 5'b01001) begin n_fail++; $display("FAIL prio_brk: req %b cause %b want 1 01001", exc_req, cause); end
        do_ack(); do_eret();
        teq = 1; zero = 0; tick(); idle_inputs();
        n_tests++; if (exc_req !== 1'b0) begin n_fail++; $display("FAIL teq_nz: req %b want 0", exc_req); end
        teq = 1; zero = 1; tick(); idle_inputs();
        n_tests++; if (exc_req !== 1'b1 || cause !== 5'b01101 || irq_id !== 2'd0) begin
            n_fail++; $display("FAIL teq_z: req %b cause %b id %0d want 1 01101 0", exc_req, cause, irq_id); end
        do_ack(); do_eret();
    endtask

    task automatic test_irq_mask();
        idle_inputs();
        write_mask(4'b1010);
        irq = 4'b1010; tick(); irq = 0;
        n_tests++; if (pending !== 4'b1010 || exc_req !== 1'b0) begin n_fail++; $display("FAIL irq_pend: pend %b req %b want 1010 0", pending, exc_req); end
        tick();
        n_tests++; if (exc_req !== 1'b1 || cause !== 5'd0 || irq_id !== 2'd1) begin
            n_fail++; $display("FAIL irq_first: req %b cause %b id %0d want 1 00000 1", exc_req, cause, irq_id); end
        do_ack();
        n_tests++; if (pending !== 4'b1000 || in_handler !== 1'b1) begin n_fail++; $display("FAIL irq_ack: pend %b inh %b want 1000 1", pending, in_handler); end
        tick();
        n_tests++; if (exc_req !== 1'b0) begin n_fail++; $display("FAIL irq_in_handler: req %b want 0", exc_req); end
        do_eret();
        n_tests++; if (exc_req !== 1'b0) begin n_fail++; $display("FAIL irq_eret_edge: req %b want 0", exc_req); end
        tick();
        n_tests++; if (exc_req !== 1'b1 || irq_id !== 2'd3) begin n_fail++; $display("FAIL irq_second: req %b id %0d want 1 3", exc_req, irq_id); end
        do_ack(); do_eret();
        n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL irq_drained: pend %b want 0000", pending); end
    endtask

    task automatic test_mask_write();
        idle_inputs();
        write_mask(4'b0000);
        irq = 4'b0001; tick(); irq = 0;
        tick(); tick();
        n_tests++; if (pending !== 4'b0001 || exc_req !== 1'b0) begin n_fail++; $display("FAIL masked: pend %b req %b want 0001 0", pending, exc_req); end
        write_mask(4'b0001);
        n_tests++; if (mask !== 4'b0001 || exc_req !== 1'b0) begin n_fail++; $display("FAIL mask_write: mask %b req %b want 0001 0", mask, exc_req); end
        tick();
        n_tests++; if (exc_req !== 1'b1 || cause !== 5'd0 || irq_id !== 2'd0) begin
            n_fail++; $display("FAIL unmask_req: req %b cause %b id %0d want 1 00000 0", exc_req, cause, irq_id); end
        do_ack(); do_eret();
    endtask

    task automatic test_double_fault();
        idle_inputs();
        syscall = 1; tick(); syscall = 0;
        do_ack();
        brk = 1; tick(); brk = 0;
        n_tests++; if (exc_req !== 1'b0 || double_fault !== 1'b1) begin n_fail++; $display("FAIL df_set: req %b df %b want 0 1", exc_req, double_fault); end
        do_eret();
        tick();
        n_tests++; if (double_fault !== 1'b1 || in_handler !== 1'b0 || exc_req !== 1'b0) begin
            n_fail++; $display("FAIL df_sticky: df %b inh %b req %b want 1 0 0", double_fault, in_handler, exc_req); end
        rst = 1; tick(); rst = 0;
        n_tests++; if (double_fault !== 1'b0 || exc_req !== 1'b0 || mask !== 4'h0 || pending !== 4'h0 || ie !== 1'b1) begin
            n_fail++; $display("FAIL df_reset: df %b req %b mask %b pend %b ie %b want 0 0 0000 0000 1", double_fault, exc_req, mask, pending, ie); end
    endtask

    task automatic test_ack_edge_collision();
        idle_inputs();
        write_mask(4'b0100);
        irq = 4'b0100; tick(); irq = 0;
        tick();
        n_tests++; if (exc_req !== 1'b1 || irq_id !== 2'd2) begin n_fail++; $display("FAIL coll_req: req %b id %0d want 1 2", exc_req, irq_id); end
        exc_ack = 1; irq = 4'b0100; tick(); exc_ack = 0; irq = 0;
        n_tests++; if (pending !== 4'b0100 || in_handler !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins: pend %b inh %b want 0100 1", pending, in_handler); end
        do_eret(); tick();
        n_tests++; if (exc_req !== 1'b1 || irq_id !== 2'd2) begin n_fail++; $display("FAIL coll_rereq: req %b id %0d want 1 2", exc_req, irq_id); end
        do_ack(); do_eret();
    endtask

    task automatic test_random();
        logic [18:0] got;
        logic [18:0] exp;
        int          shown = 0;
        idle_inputs();
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            syscall    = ($urandom_range(0, 15) == 0);
            brk        = ($urandom_range(0, 15) == 0);
            teq        = ($urandom_range(0, 7) == 0);
            zero       = $urandom_range(0, 1) != 0;
            irq        = 4'($urandom_range(0, 15));
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            exc_ack    = ($urandom_range(0, 2) == 0);
            eret       = ($urandom_range(0, 3) == 0);
            tick();
            got = {exc_req, pending, mask, ie, in_handler, double_fault, exc_req ? {cause, irq_id} : 7'd0};
            exp = {m_req, m_pend, m_mask, m_ie, m_hand, m_df, m_req ? {m_cause, m_id} : 7'd0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random cycle %0d: got %b want %b", c, got, exp);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_req = 0; m_hand = 0; m_ie = 1; m_df = 0;
        m_cause = 0; m_id = 0; m_pend = 0; m_mask = 0; m_prev = 0;
        test_reset();
        test_syscall();
        test_priority();
        test_irq_mask();
        test_mask_write();
        test_double_fault();
        test_ack_edge_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_intr_ctrl.md
Name: exc_intr_ctrl

Overview:
- Parametrised exception/interrupt controller for the static pipeline CPU.
- Prioritises synchronous exceptions (syscall, break, trap-on-equal) and NUM_IRQ edge-triggered external interrupts.
- Latches interrupt sources into a pending register, gates them with a writable mask and a global enable, and presents one registered cause to the pipeline with a req/ack handshake.
- Tracks handler entry and eret exit.

Parameters:
- NUM_IRQ, 4, number of external interrupt inputs (1..8).
- IRQ_ID_W, 2, width of irq_id; 2**IRQ_ID_W >= NUM_IRQ required.
- CAUSE_W, 5, width of cause code.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- syscall  in  1  syscall decoded in current instruction
- brk  in  1  break decoded
- teq  in  1  teq decoded
- zero  in  1  ALU zero for teq compare
- irq  in  NUM_IRQ  external interrupt lines, same clock domain
- mask_we  in  1  write strobe for interrupt mask
- mask_wdata  in  NUM_IRQ  new mask, 1 = enabled
- exc_ack  in  1  pipeline has flushed and redirected to the handler
- eret  in  1  eret retired
- exc_req  out  1  exception request to pipeline
- cause  out  CAUSE_W  cause code, valid while exc_req = 1
- irq_id  out  IRQ_ID_W  interrupt index when cause = 0
- pending  out  NUM_IRQ  pending register
- mask  out  NUM_IRQ  mask register
- ie  out  1  global interrupt enable
- in_handler  out  1  handler active
- double_fault  out  1  sticky: synchronous exception while not IDLE

Behaviour:
- Reset (rst = 1 at a clock edge):
  - state IDLE; exc_req, cause, irq_id, pending, mask, in_handler and double_fault all 0; ie = 1.
  - The irq edge-history register is cleared to 0.
  - A level already high when reset releases produces an edge on the first cycle after reset.
- Edge detect and pending:
  - irq_q <= irq each cycle.
  - pending[i] is set when irq[i] & ~irq_q[i].
  - pending[i] is cleared on the ack of an interrupt with irq_id = i.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Pending updates happen in every state.
- Mask: on mask_we, mask <= mask_wdata; the new value takes effect for selection from the next cycle.
- Cause codes and priority, highest first:
  - syscall = 01000
  - brk = 01001
  - teq & zero = 01101
  - interrupt = 00000, with irq_id = lowest index i where pending[i] & mask[i]. Interrupts are eligible only when ie = 1.
- State machine (IDLE, REQ, HANDLER):
  - IDLE: if any eligible source, next cycle go to REQ with exc_req = 1; cause and irq_id are registered from that cycle's inputs.
  - IDLE: latency from a synchronous input to exc_req is 1 cycle; from an irq edge it is 2 cycles (edge to pending, then pending to req).
  - REQ: exc_req, cause and irq_id are held stable until exc_ack. On the exc_ack cycle: next state HANDLER, exc_req <= 0, ie <= 0, in_handler <= 1, and the pending bit is cleared if cause = 0.
  - HANDLER: eret -> IDLE next cycle, ie <= 1, in_handler <= 0. Pending interrupts may re-request starting the cycle after the return to IDLE.
  - eret in IDLE or REQ is ignored.
  - exc_ack outside REQ is ignored.
- Not-IDLE faults: a synchronous exception (syscall, brk, or teq & zero) in REQ or HANDLER is not taken and sets double_fault. double_fault is cleared only by rst.
- Reset mid-operation: rst overrides all other inputs that cycle; exc_req drops on the next edge.
- Width rule: irq_id is zero-extended index; unused ids never produced.

Test Plan:
- Reset, then syscall = 1 for one cycle -> next cycle exc_req = 1, cause = 01000. exc_req stays 1 with no ack; exc_ack -> HANDLER, ie = 0, in_handler = 1.
- syscall, brk and teq with zero = 1 in the same cycle -> cause = 01000. brk with teq, zero = 1 -> 01001. teq with zero = 0 -> no request.
- mask = 4'b1010; pulse irq[3] then irq[1] together -> pending = 1010, request cause = 0, irq_id = 1. After ack, pending = 1000. After eret, second request with irq_id = 3.
- Pulse irq[0] with mask[0] = 0 -> pending[0] = 1, no request. Write mask = 0001 -> request on the cycle after the write takes effect, irq_id = 0.
- In HANDLER, assert brk -> no request, double_fault = 1 and stays set after eret. Then rst -> all outputs 0, ie = 1.
- irq[2] rising edge in the same cycle as the ack of irq_id = 2 -> pending[2] remains 1.
